// File: rtl/ram_access_sequencer_pkg.sv
// RAM_shared_pkg: shared definitions for the SPI RAM access sequencer.
//   CMD_*        : 2-bit command codes placed in ram_din[ADDR_SIZE+1:ADDR_SIZE]
//   seq_state_e  : sequencer FSM state encoding
package RAM_shared_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WADDR,
        WDATA,
        RADDR,
        RDATA,
        RWAIT,
        RESP
    } seq_state_e;

endpackage

// File: rtl/ram_access_sequencer_rr_arb2.sv
// rr_arb2: two-input round-robin arbiter.
//   clk, rst        : clock, async active-high reset
//   valid0, valid1  : request lines
//   accept          : a grant was taken this cycle; advance the pointer
//   grant0, grant1  : combinational one-hot (or zero) grant
// last_grant resets to 1 so requester 0 wins the first contended cycle.
module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic valid0,
    input  logic valid1,
    input  logic accept,
    output logic grant0,
    output logic grant1
);

    logic last_grant;

    // A lone requester always wins; on contention the one not served last wins.
    always_comb begin
        grant0 = valid0 && (!valid1 || last_grant);
        grant1 = valid1 && (!valid0 || !last_grant);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_grant <= 1'b1;
        else if (accept)
            last_grant <= grant1;
    end

endmodule

// File: rtl/ram_access_sequencer.sv
// ram_access_sequencer: shares a single-port SPI RAM between two word-level
// requesters, turning each accepted request into the RAM's command stream
// and returning exactly one response per request.
//   clk, rst                          : clock, async active-high reset
//   reqN_valid/wr/addr/wdata/ready    : requester N handshake (N = 0, 1)
//   ram_din, ram_rx_valid             : registered command word to the RAM
//   ram_dout, ram_tx_valid            : read data returned by the RAM
//   resp_valid/id/rdata/err           : one-cycle completion pulse
module ram_access_sequencer
    import RAM_shared_pkg::*;
#(
    parameter int ADDR_SIZE  = 8,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    input  logic                 req0_wr,
    input  logic [ADDR_SIZE-1:0] req0_addr,
    input  logic [ADDR_SIZE-1:0] req0_wdata,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic                 req1_wr,
    input  logic [ADDR_SIZE-1:0] req1_addr,
    input  logic [ADDR_SIZE-1:0] req1_wdata,
    output logic                 req1_ready,
    output logic [ADDR_SIZE+1:0] ram_din,
    output logic                 ram_rx_valid,
    input  logic [ADDR_SIZE-1:0] ram_dout,
    input  logic                 ram_tx_valid,
    output logic                 resp_valid,
    output logic                 resp_id,
    output logic [ADDR_SIZE-1:0] resp_rdata,
    output logic                 resp_err
);

    localparam int              CW       = $clog2(RD_TIMEOUT + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(RD_TIMEOUT - 1);

    seq_state_e state, state_next;

    logic                 grant0, grant1, accept;
    logic                 sel_id, sel_wr;
    logic [ADDR_SIZE-1:0] sel_addr, sel_wdata;

    logic                 id_q;
    logic [ADDR_SIZE-1:0] wdata_q;
    logic [CW-1:0]        cnt, cnt_next;

    logic                 rx_next;
    logic [ADDR_SIZE+1:0] din_next;
    logic                 resp_load;
    logic [ADDR_SIZE-1:0] rdata_next;
    logic                 err_next;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid0 (req0_valid),
        .valid1 (req1_valid),
        .accept (accept),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    always_comb begin
        req0_ready = (state == IDLE) && grant0;
        req1_ready = (state == IDLE) && grant1;
        accept     = req0_ready || req1_ready;
        sel_id     = grant1;
        sel_wr     = grant1 ? req1_wr    : req0_wr;
        sel_addr   = grant1 ? req1_addr  : req0_addr;
        sel_wdata  = grant1 ? req1_wdata : req0_wdata;
    end

    // Next-state logic. ram_din/ram_rx_valid are registered, so the command
    // word is produced for the state being entered, not the current one.
    // The address goes straight from the requester into ram_din on accept,
    // so only write data needs its own holding register.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        rx_next    = 1'b0;
        din_next   = '0;
        resp_load  = 1'b0;
        rdata_next = '0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    rx_next = 1'b1;
                    if (sel_wr) begin
                        state_next = WADDR;
                        din_next   = {CMD_WR_ADDR, sel_addr};
                    end else begin
                        state_next = RADDR;
                        din_next   = {CMD_RD_ADDR, sel_addr};
                    end
                end
            end
            WADDR: begin
                state_next = WDATA;
                rx_next    = 1'b1;
                din_next   = {CMD_WR_DATA, wdata_q};
            end
            WDATA: begin
                state_next = RESP;
                resp_load  = 1'b1;
            end
            RADDR: begin
                state_next = RDATA;
                rx_next    = 1'b1;
                din_next   = {CMD_RD_DATA, {ADDR_SIZE{1'b0}}};
            end
            RDATA: begin
                state_next = RWAIT;
                cnt_next   = '0;
            end
            RWAIT: begin
                // Data arriving on the final timeout cycle still counts.
                if (ram_tx_valid) begin
                    state_next = RESP;
                    resp_load  = 1'b1;
                    rdata_next = ram_dout;
                end else if (cnt == CNT_LAST) begin
                    state_next = RESP;
                    resp_load  = 1'b1;
                    rdata_next = '1;
                    err_next   = 1'b1;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt          <= '0;
            id_q         <= 1'b0;
            wdata_q      <= '0;
            ram_rx_valid <= 1'b0;
            ram_din      <= '0;
            resp_valid   <= 1'b0;
            resp_id      <= 1'b0;
            resp_rdata   <= '0;
            resp_err     <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            ram_rx_valid <= rx_next;
            ram_din      <= din_next;
            resp_valid   <= resp_load;
            if (accept) begin
                id_q    <= sel_id;
                wdata_q <= sel_wdata;
            end
            if (resp_load) begin
                resp_id    <= id_q;
                resp_rdata <= rdata_next;
                resp_err   <= err_next;
            end
        end
    end

endmodule

// File: doc/ram_access_sequencer.md
Name: ram_access_sequencer

Overview:
- Shares the single-port SPI RAM between two word-level requesters: req0 (SPI slave path) and req1 (host/debug port).
- Arbitrates round-robin between them.
- Converts each accepted request into the RAM's 10-bit command sequence: din[9:8] 00 = write address, 01 = write data, 10 = read address, 11 = read data.
- Waits for ram_tx_valid on reads and returns one response per request, with a read timeout.

Parameters:
- ADDR_SIZE, 8, RAM address and data width (din = {2-bit cmd, ADDR_SIZE bits}).
- RD_TIMEOUT, 15, maximum cycles spent in RWAIT before a read aborts with error.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has a request.
- req0_wr  in  1  1 = write, 0 = read.
- req0_addr  in  ADDR_SIZE  address.
- req0_wdata  in  ADDR_SIZE  write data.
- req0_ready  out  1  request accepted this cycle (valid && ready).
- req1_valid, req1_wr, req1_addr, req1_wdata, req1_ready: same as requester 0.
- ram_din  out  ADDR_SIZE+2  command word to RAM.
- ram_rx_valid  out  1  ram_din valid this cycle.
- ram_dout  in  ADDR_SIZE  RAM read data.
- ram_tx_valid  in  1  ram_dout valid.
- resp_valid  out  1  one-cycle completion pulse.
- resp_id  out  1  requester that owns the response.
- resp_rdata  out  ADDR_SIZE  read data; 0 for writes, all-ones on timeout.
- resp_err  out  1  read timed out.

Behaviour:
- Reset (async, rst=1):
  - state = IDLE; last_grant = 1, so req0 wins first.
  - ram_rx_valid = 0, ram_din = 0.
  - resp_valid = 0, resp_id = 0, resp_rdata = 0, resp_err = 0.
  - Timeout counter = 0.
  - Any in-flight request is dropped and produces no response.
- FSM states: IDLE, WADDR, WDATA, RADDR, RDATA, RWAIT, RESP.
- IDLE:
  - Combinational grant. If exactly one valid, that requester is granted.
  - If both valid, the requester != last_grant is granted.
  - reqN_ready = (state==IDLE) && grantN. Never both high.
  - On accept: latch id/wr/addr/wdata, update last_grant, go to WADDR (wr=1) or RADDR (wr=0).
  - Requesters hold valid and payload stable until ready.
- WADDR: rx_valid=1, din={00,addr} -> WDATA.
- WDATA: rx_valid=1, din={01,wdata} -> RESP with rdata=0, err=0.
- RADDR: rx_valid=1, din={10,addr} -> RDATA.
- RDATA: rx_valid=1, din={11,8'h00} -> RWAIT; counter cleared.
- RWAIT:
  - rx_valid=0.
  - If ram_tx_valid: capture ram_dout -> RESP, err=0.
  - Else counter++. When counter reaches RD_TIMEOUT -> RESP with rdata=all-ones, err=1.
  - ram_tx_valid and timeout in the same cycle: data wins, err=0.
- RESP: resp_valid=1 for exactly one cycle, resp_id = latched id -> IDLE.
- ram_rx_valid and ram_din are registered outputs; ram_rx_valid is 0 in IDLE, RWAIT and RESP.
- Stray ram_tx_valid outside RWAIT is ignored.
- Latency, accept at cycle T:
  - Write: WADDR T+1, WDATA T+2, resp_valid T+3, next accept T+4.
  - Read with a 1-cycle RAM: tx_valid sampled T+3, resp_valid T+4.
- ram_din is never 11 without a preceding 10 for the same request; 01 always follows 00.

Decomposition:
- Add to RAM_shared_pkg:
  - Command localparams CMD_WR_ADDR=2'b00, CMD_WR_DATA=2'b01, CMD_RD_ADDR=2'b10, CMD_RD_DATA=2'b11.
  - State enum seq_state_e.
- One sub-module, rr_arb2: 2-input round-robin grant with a last_grant register and update-on-accept input.

Test Plan:
- Write from req0 (addr 8'h3A, data 8'h5C) -> rx_valid at T+1/T+2 with din 10'h03A then 10'h15C; resp_valid at T+3, id=0, rdata=0, err=0.
- Read from req1 at 8'h3A with a RAM model returning 8'h5C one cycle after 11 -> din 10'h23A then 10'h300; resp_valid at T+4, id=1, rdata=8'h5C.
- req0 and req1 held valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; ready never both high.
- Read with ram_tx_valid withheld -> after RD_TIMEOUT=15 cycles in RWAIT, resp_valid with err=1, rdata=8'hFF; next request is accepted normally.
- Assert rst during RWAIT (asynchronously, mid-cycle) -> ram_rx_valid and resp_valid go 0 immediately; no response for the dropped read; after release req0 is granted first.
- ram_tx_valid pulsed while IDLE and during WDATA -> no resp_valid, no state change.
